// File: rtl/rst_seq.sv
// rst_seq: reset release sequencer placed downstream of the reset synchronizer.
// Releases NUM_STAGES active-low reset outputs in order 0..N-1. Each release waits
// STAGE_DLY cycles, then the stage's ready ack must arrive before the next stage
// starts its delay. A missing ack for ACK_TO cycles flags an error. A software warm
// reset request (accepted only when idle in DONE or ERR) re-asserts the outputs from
// the top stage down and then re-sequences from stage 0.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset (already synchronized upstream)
//   sw_rst_req  one-cycle warm re-sequence request, ignored while busy
//   stage_ack   per-stage ready, asynchronous, double-flopped here
//   rst_out_n   sequenced active-low resets, bit i = stage i
//   seq_done    all stages released and acknowledged
//   seq_err     ack timeout occurred
//   err_stage   stage that timed out (meaningful while seq_err=1)
//   busy        sequencing or re-asserting
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_DLY    | counting STAGE_DLY cycles before releasing the current stage
// ST_WAIT   | stage released, waiting for its synchronized ack
// ST_DONE   | every stage released and acked, idle
// ST_ERR    | ack timeout on err_stage, idle
// ST_ASSERT | warm reset: clearing outputs from the top index down to 0
module rst_seq #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 8,
    parameter int STAGE_DLY  = 16,
    parameter int ACK_TO     = 255,
    parameter int STG_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic [STG_W-1:0]      err_stage,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_DLY,
        ST_WAIT,
        ST_DONE,
        ST_ERR,
        ST_ASSERT
    } state_t;

    localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'(STAGE_DLY - 1);
    // With ACK_TO=0 this wraps to all ones, but TO_EN keeps it from ever being used.
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ACK_TO - 1);
    localparam bit               TO_EN      = (ACK_TO != 0);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);
    localparam logic [STG_W-1:0] NEXT_DOWN  = STG_W'(NUM_STAGES - 2);

    state_t                state;
    logic [STG_W-1:0]      stage;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_STAGES-1:0] ack_meta;
    logic [NUM_STAGES-1:0] ack_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= '0;
            ack_s    <= '0;
        end else begin
            ack_meta <= stage_ack;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_DLY;
            stage     <= '0;
            cnt       <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b0;
            err_stage <= '0;
            busy      <= 1'b1;
        end else begin
            unique case (state)
                ST_DLY: begin
                    if (cnt == DLY_LAST) begin
                        rst_out_n[stage] <= 1'b1;
                        cnt              <= '0;
                        state            <= ST_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (ack_s[stage]) begin
                        if (stage == LAST_STAGE) begin
                            state    <= ST_DONE;
                            seq_done <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            stage <= stage + 1'b1;
                            cnt   <= '0;
                            state <= ST_DLY;
                        end
                    end else if (TO_EN && cnt == TO_LAST) begin
                        state     <= ST_ERR;
                        seq_err   <= 1'b1;
                        err_stage <= stage;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    // The top output is cleared on the accept edge itself, so the
                    // down-walk continues from NUM_STAGES-2.
                    if (sw_rst_req) begin
                        seq_done                  <= 1'b0;
                        seq_err                   <= 1'b0;
                        busy                      <= 1'b1;
                        rst_out_n[NUM_STAGES-1]   <= 1'b0;
                        stage                     <= NEXT_DOWN;
                        state                     <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    rst_out_n[stage] <= 1'b0;
                    if (stage == '0) begin
                        cnt   <= '0;
                        state <= ST_DLY;
                    end else begin
                        stage <= stage - 1'b1;
                    end
                end
                default: begin
                    state <= ST_DLY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: self-checking bench for rst_seq. A behavioural model tracks how many
// stages are released / acknowledged and cycles spent in the current phase; a compare
// process checks every DUT output against it each cycle. Directed scenarios pin the
// model with hand-computed edge numbers, followed by randomized ack/request/reset traffic.
module tb_rst_seq;
    localparam int N         = 4;
    localparam int CNT_W     = 8;
    localparam int STAGE_DLY = 16;
    localparam int ACK_TO    = 255;
    localparam int STG_W     = 2;

    logic           clk_free = 1'b0;
    logic           clk_en   = 1'b1;
    logic           clk;
    logic           rst_n;
    logic           sw_rst_req;
    logic [N-1:0]   stage_ack;
    logic [N-1:0]   rst_out_n;
    logic           seq_done;
    logic           seq_err;
    logic [STG_W-1:0] err_stage;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    always #5 clk_free = ~clk_free;
    assign clk = clk_free & clk_en;

    rst_seq #(
        .NUM_STAGES(N),
        .CNT_W     (CNT_W),
        .STAGE_DLY (STAGE_DLY),
        .ACK_TO    (ACK_TO),
        .STG_W     (STG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst_req(sw_rst_req),
        .stage_ack (stage_ack),
        .rst_out_n (rst_out_n),
        .seq_done  (seq_done),
        .seq_err   (seq_err),
        .err_stage (err_stage),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_rel = 0;      // stages released
    int           m_acked = 0;    // stages whose ack was accepted
    int           m_elapsed = 0;  // edges spent in the current delay / wait phase
    int           m_lim = N;      // during warm reset, bits at or above m_lim are forced low
    bit           m_unw = 0;      // warm reset walk in progress
    bit           m_done = 0;
    bit           m_err = 0;
    int           m_err_stage = 0;
    logic [N-1:0] m_pin1 = '0;    // ack pin captured one edge ago
    logic [N-1:0] m_pin2 = '0;    // ack pin captured two edges ago: what the DUT may act on

    always @(posedge clk or negedge rst_n) begin
        int rel, acked, elapsed, lim, est;
        bit unw, done, err;
        logic [N-1:0] seen;
        if (!rst_n) begin
            m_rel <= 0; m_acked <= 0; m_elapsed <= 0; m_lim <= N;
            m_unw <= 0; m_done <= 0; m_err <= 0; m_err_stage <= 0;
            m_pin1 <= '0; m_pin2 <= '0;
            edge_no <= 0;
        end else begin
            rel = m_rel; acked = m_acked; elapsed = m_elapsed; lim = m_lim;
            unw = m_unw; done = m_done; err = m_err; est = m_err_stage;
            seen = m_pin2;
            if (unw) begin
                lim = lim - 1;
                if (lim == 0) begin
                    unw = 0; rel = 0; acked = 0; elapsed = 0; lim = N;
                end
            end else if (done || err) begin
                if (sw_rst_req) begin
                    done = 0; err = 0; unw = 1; lim = N - 1;
                end
            end else if (rel == acked) begin
                elapsed = elapsed + 1;
                if (elapsed == STAGE_DLY) begin
                    rel = rel + 1; elapsed = 0;
                end
            end else begin
                if (seen[acked]) begin
                    acked = acked + 1; elapsed = 0;
                    if (acked == N) done = 1;
                end else begin
                    elapsed = elapsed + 1;
                    if (ACK_TO != 0 && elapsed == ACK_TO) begin
                        err = 1; est = acked;
                    end
                end
            end
            m_rel <= rel; m_acked <= acked; m_elapsed <= elapsed; m_lim <= lim;
            m_unw <= unw; m_done <= done; m_err <= err; m_err_stage <= est;
            m_pin2 <= m_pin1; m_pin1 <= stage_ack;
            edge_no <= edge_no + 1;
        end
    end

    function automatic int exp_mask();
        int m;
        m = (1 << m_rel) - 1;
        if (m_unw) m = m & ((1 << m_lim) - 1);
        return m;
    endfunction

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            chk("reset rst_out_n", int'(rst_out_n), 0);
            chk("reset seq_done", int'(seq_done), 0);
            chk("reset seq_err", int'(seq_err), 0);
            chk("reset err_stage", int'(err_stage), 0);
            chk("reset busy", int'(busy), 1);
        end else begin
            chk("rst_out_n", int'(rst_out_n), exp_mask());
            chk("seq_done", int'(seq_done), int'(m_done));
            chk("seq_err", int'(seq_err), int'(m_err));
            chk("busy", int'(busy), int'(!(m_done || m_err)));
            if (m_err) chk("err_stage", int'(err_stage), m_err_stage);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rise(input int b, input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            nclk();
            if (rst_out_n[b]) begin
                e = edge_no;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_rise: rst_out_n[%0d] got 0 expected 1 within %0d cycles", b, budget);
    endtask

    // sel 0 waits for seq_done, sel 1 for seq_err
    task automatic wait_flag(input int sel, input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            nclk();
            if ((sel == 0 && seq_done) || (sel == 1 && seq_err)) begin
                e = edge_no;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_flag: flag %0d got 0 expected 1 within %0d cycles", sel, budget);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t, r1, r2, tog, rate;
        rst_n      = 1'b1;
        sw_rst_req = 1'b0;
        stage_ack  = 4'hF;
        #1 rst_n = 1'b0;
        #1;
        chk("t1 reset rst_out_n", int'(rst_out_n), 0);
        chk("t1 reset busy", int'(busy), 1);
        chk("t1 reset seq_done", int'(seq_done), 0);
        chk("t1 reset err_stage", int'(err_stage), 0);

        // Test 1: all acks high from the start
        repeat (3) nclk();
        rst_n = 1'b1;
        wait_rise(0, 100, e); chk("t1 stage0 edge", e, 16);
        wait_rise(1, 100, e); chk("t1 stage1 edge", e, 33);
        wait_rise(2, 100, e); chk("t1 stage2 edge", e, 50);
        wait_rise(3, 100, e); chk("t1 stage3 edge", e, 67);
        wait_flag(0, 100, e); chk("t1 done edge", e, 68);
        chk("t1 busy after done", int'(busy), 0);

        // Test 4: warm reset from DONE
        nclk(); sw_rst_req = 1'b1;
        nclk(); sw_rst_req = 1'b0;
        chk("t4 walk 0", int'(rst_out_n), 4'b0111);
        chk("t4 done cleared", int'(seq_done), 0);
        chk("t4 busy set", int'(busy), 1);
        nclk(); chk("t4 walk 1", int'(rst_out_n), 4'b0011);
        nclk(); chk("t4 walk 2", int'(rst_out_n), 4'b0001);
        nclk(); chk("t4 walk 3", int'(rst_out_n), 4'b0000);
        t = edge_no;
        wait_rise(0, 100, e); chk("t4 re-release stage0", e - t, 16);
        wait_flag(0, 200, e); chk("t4 re-done", e - t, 68);

        // Tests 2, 3, 5: late ack on stage 1, stuck stage 2, requests while busy
        nclk(); rst_n = 1'b0; stage_ack = 4'b0001;
        nclk(); rst_n = 1'b1;
        repeat (5) nclk();
        sw_rst_req = 1'b1;
        nclk(); sw_rst_req = 1'b0;
        wait_rise(1, 100, r1); chk("t2 stage1 edge", r1, 33);
        for (int i = 0; i < 40; i++) begin
            sw_rst_req = (i == 10);
            nclk();
        end
        sw_rst_req = 1'b0;
        tog = edge_no;
        stage_ack[1] = 1'b1;
        wait_rise(2, 100, r2); chk("t2 stage2 after toggle", r2 - tog, 19);
        chk("t2 no err", int'(seq_err), 0);
        wait_flag(1, 400, e); chk("t3 err edge", e - r2, 255);
        chk("t3 rst_out_n", int'(rst_out_n), 4'b0111);
        chk("t3 err_stage", int'(err_stage), 2);
        chk("t3 busy", int'(busy), 0);

        // Test 6: recover from ERR
        stage_ack = 4'hF;
        sw_rst_req = 1'b1;
        nclk(); sw_rst_req = 1'b0;
        chk("t6 err cleared", int'(seq_err), 0);
        chk("t6 busy", int'(busy), 1);
        chk("t6 walk 0", int'(rst_out_n), 4'b0111);
        wait_flag(0, 200, e);
        chk("t6 done outputs", int'(rst_out_n), 4'hF);

        // Test 5b: async reset with the clock stopped
        nclk(); rst_n = 1'b0;
        nclk(); rst_n = 1'b1;
        repeat (40) nclk();
        chk("t5 mid-seq outputs", int'(rst_out_n), 4'b0011);
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t5 async rst_out_n", int'(rst_out_n), 0);
        chk("t5 async busy", int'(busy), 1);
        repeat (3) @(negedge clk_free);
        clk_en = 1'b1;
        repeat (2) nclk();
        rst_n = 1'b1;

        // Randomized traffic
        for (int ep = 0; ep < 8; ep++) begin
            rate = (ep % 3 == 0) ? 8 : ((ep % 3 == 1) ? 60 : 500);
            for (int c = 0; c < 2000; c++) begin
                nclk();
                if (!rst_n) begin
                    if ($urandom_range(0, 1) == 0) rst_n = 1'b1;
                end else if ($urandom_range(0, 1499) == 0) begin
                    rst_n = 1'b0;
                end
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, rate - 1) == 0) stage_ack[b] = ~stage_ack[b];
                sw_rst_req = ($urandom_range(0, 39) == 0);
            end
        end
        sw_rst_req = 1'b0;
        rst_n = 1'b1;
        repeat (3) nclk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
